// File: rtl/dispatch_queue.sv
// -----------------------------------------------------------------------------
// dispatch_queue
//
// In-order queue of decoded instructions. It sits between the decode stage and
// the functional-unit reservation stations. Each cycle it accepts one decoded
// op and buffers up to DEPTH entries. The head entry is offered to the ALU, BU,
// load (DUL) or store (DUS) station, chosen by the class field in aluop[8:6].
//
// Class encoding of aluop[8:6]:
//   3'd1 ALU, 3'd2 BU, 3'd3 DUL (load), 3'd4 DUS (store).
//   Any other value is an unknown class. Such an entry is dropped at the head
//   and pulses 'illegal'.
//
// Ports
//   clk, rst_n             clock and asynchronous active-low reset
//   flush                  synchronous clear of all queued entries
//   in_valid / in_ready    enqueue handshake; in_ready depends only on occupancy
//   in_aluop .. in_imm     decoded op payload
//   <u>_valid / <u>_ready  dispatch handshake per unit (alu, bu, dul, dus)
//   out_aluop .. out_imm   head payload, shared by all units
//   illegal                head had an unknown class and is discarded this cycle
//   count                  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module dispatch_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8:0]               in_aluop,
    input  logic                     in_regw,
    input  logic [4:0]               in_rsrc1,
    input  logic [4:0]               in_rsrc2,
    input  logic [4:0]               in_rdst,
    input  logic [DATA_W-1:0]        in_imm,
    output logic                     alu_valid,
    input  logic                     alu_ready,
    output logic                     bu_valid,
    input  logic                     bu_ready,
    output logic                     dul_valid,
    input  logic                     dul_ready,
    output logic                     dus_valid,
    input  logic                     dus_ready,
    output logic [8:0]               out_aluop,
    output logic                     out_regw,
    output logic [4:0]               out_rsrc1,
    output logic [4:0]               out_rsrc2,
    output logic [4:0]               out_rdst,
    output logic [DATA_W-1:0]        out_imm,
    output logic                     illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] CLASS_ALU = 3'd1;
    localparam logic [2:0] CLASS_BU  = 3'd2;
    localparam logic [2:0] CLASS_DUL = 3'd3;
    localparam logic [2:0] CLASS_DUS = 3'd4;

    typedef struct packed {
        logic [8:0]        aluop;
        logic              regw;
        logic [4:0]        rsrc1;
        logic [4:0]        rsrc2;
        logic [4:0]        rdst;
        logic [DATA_W-1:0] imm;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    entry_t             head;
    entry_t             in_entry;
    logic               not_empty;
    logic               enq;
    logic               retire;

    // Head decode and handshakes. Everything here comes from registered state
    // and the downstream ready inputs. No in_* signal reaches an output.
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        not_empty = (count_q != '0);

        alu_valid = not_empty && (head.aluop[8:6] == CLASS_ALU);
        bu_valid  = not_empty && (head.aluop[8:6] == CLASS_BU);
        dul_valid = not_empty && (head.aluop[8:6] == CLASS_DUL);
        dus_valid = not_empty && (head.aluop[8:6] == CLASS_DUS);

        // An unknown class retires on its own in the same cycle it reaches the head.
        illegal   = not_empty && !(alu_valid || bu_valid || dul_valid || dus_valid);

        retire    = (alu_valid && alu_ready) || (bu_valid  && bu_ready)  ||
                    (dul_valid && dul_ready) || (dus_valid && dus_ready) ||
                    illegal;

        // A full queue refuses input even when the head leaves this cycle.
        // This keeps in_ready free of any path from the downstream readies.
        in_ready  = (count_q != CNT_W'(DEPTH));
        enq       = in_valid && in_ready && !flush;

        out_aluop = head.aluop;
        out_regw  = head.regw;
        out_rsrc1 = head.rsrc1;
        out_rsrc2 = head.rsrc2;
        out_rdst  = head.rdst;
        out_imm   = head.imm;
        count     = count_q;
    end

    // Next-state for the pointers and the occupancy count.
    always_comb begin
        in_entry = '{aluop: in_aluop, regw: in_regw, rsrc1: in_rsrc1,
                     rsrc2: in_rsrc2, rdst: in_rdst, imm: in_imm};
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap at the natural
            // overflow of their width.
            rd_ptr_d = rd_ptr_q + PTR_W'(retire);
            wr_ptr_d = wr_ptr_q + PTR_W'(enq);
            case ({enq, retire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments. All flops then
    // update together at the edge, whatever order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the entry storage is deliberately not reset. Nothing reads a slot
    // before it is written, because all *_valid outputs are gated by count.
    // Leaving it unreset lets the storage map onto plain RAM or flops without
    // a reset net.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
module tb_dispatch_queue;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;

    localparam logic [2:0] C_ALU = 3'd1;
    localparam logic [2:0] C_BU  = 3'd2;
    localparam logic [2:0] C_DUL = 3'd3;
    localparam logic [2:0] C_DUS = 3'd4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [8:0]        in_aluop;
    logic              in_regw;
    logic [4:0]        in_rsrc1, in_rsrc2, in_rdst;
    logic [DATA_W-1:0] in_imm;
    logic              alu_valid, alu_ready, bu_valid, bu_ready;
    logic              dul_valid, dul_ready, dus_valid, dus_ready;
    logic [8:0]        out_aluop;
    logic              out_regw;
    logic [4:0]        out_rsrc1, out_rsrc2, out_rdst;
    logic [DATA_W-1:0] out_imm;
    logic              illegal;
    logic [3:0]        count;

    dispatch_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_regw(in_regw), .in_rsrc1(in_rsrc1),
        .in_rsrc2(in_rsrc2), .in_rdst(in_rdst), .in_imm(in_imm),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .bu_valid(bu_valid), .bu_ready(bu_ready),
        .dul_valid(dul_valid), .dul_ready(dul_ready),
        .dus_valid(dus_valid), .dus_ready(dus_ready),
        .out_aluop(out_aluop), .out_regw(out_regw), .out_rsrc1(out_rsrc1),
        .out_rsrc2(out_rsrc2), .out_rdst(out_rdst), .out_imm(out_imm),
        .illegal(illegal), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]        aluop;
        logic              regw;
        logic [4:0]        rsrc1;
        logic [4:0]        rsrc2;
        logic [4:0]        rdst;
        logic [DATA_W-1:0] imm;
    } ent_t;

    ent_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] cls, input logic [5:0] opc);
        in_valid = v;
        in_aluop = {cls, opc};
        in_regw  = 1'($urandom);
        in_rsrc1 = 5'($urandom);
        in_rsrc2 = 5'($urandom);
        in_rdst  = 5'($urandom);
        in_imm   = DATA_W'($urandom);
    endtask

    task automatic set_ready(input logic a, input logic b, input logic l, input logic s);
        alu_ready = a;
        bu_ready  = b;
        dul_ready = l;
        dus_ready = s;
    endtask

    // One clock cycle. At the falling edge, compare the DUT outputs with the
    // model, then advance the model. Inputs may then change at posedge + 1.
    task automatic cycle();
        ent_t        h;
        ent_t        n;
        logic        hv, ea, eb, el, es, ei, ret, acc;
        logic [2:0]  c;
        int          sz;
        @(negedge clk);
        sz = sb.size();
        chk("count",    64'(count),    64'(sz));
        chk("in_ready", 64'(in_ready), 64'(sz != DEPTH));
        hv = (sz != 0);
        ea = 1'b0; eb = 1'b0; el = 1'b0; es = 1'b0; ei = 1'b0;
        if (hv) begin
            h  = sb[0];
            c  = h.aluop[8:6];
            ea = (c == C_ALU);
            eb = (c == C_BU);
            el = (c == C_DUL);
            es = (c == C_DUS);
            ei = !(ea || eb || el || es);
            chk("out_aluop", 64'(out_aluop), 64'(h.aluop));
            chk("out_regw",  64'(out_regw),  64'(h.regw));
            chk("out_rsrc1", 64'(out_rsrc1), 64'(h.rsrc1));
            chk("out_rsrc2", 64'(out_rsrc2), 64'(h.rsrc2));
            chk("out_rdst",  64'(out_rdst),  64'(h.rdst));
            chk("out_imm",   64'(out_imm),   64'(h.imm));
        end
        chk("alu_valid", 64'(alu_valid), 64'(ea));
        chk("bu_valid",  64'(bu_valid),  64'(eb));
        chk("dul_valid", 64'(dul_valid), 64'(el));
        chk("dus_valid", 64'(dus_valid), 64'(es));
        chk("illegal",   64'(illegal),   64'(ei));

        ret = (ea && alu_ready) || (eb && bu_ready) || (el && dul_ready) ||
              (es && dus_ready) || ei;
        acc = in_valid && (sz != DEPTH);
        if (flush) begin
            sb.delete();
        end else begin
            if (ret) void'(sb.pop_front());
            if (acc) begin
                n.aluop = in_aluop; n.regw = in_regw; n.rsrc1 = in_rsrc1;
                n.rsrc2 = in_rsrc2; n.rdst = in_rdst; n.imm = in_imm;
                sb.push_back(n);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        set_ready(0, 0, 0, 0);
        drive(0, C_ALU, 6'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state: empty, ready, nothing offered.
        cycle();

        // 1: a single ALU op appears one cycle after enqueue and retires at once.
        alu_ready = 1'b1;
        drive(1, C_ALU, 6'h20);
        cycle();
        drive(0, C_ALU, 6'd0);
        cycle();
        cycle();

        // 2: fill to DEPTH with everything stalled. The 9th op is refused.
        // Then drain in order, one per cycle.
        set_ready(0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            drive(1, 3'(i % 4 + 1), 6'(i));
            cycle();
        end
        drive(0, C_ALU, 6'd0);
        cycle();
        set_ready(1, 1, 1, 1);
        repeat (9) cycle();

        // 3: a stalled load at the head blocks the store behind it.
        set_ready(0, 0, 0, 0);
        drive(1, C_DUL, 6'h23);
        cycle();
        drive(1, C_DUS, 6'h2b);
        cycle();
        drive(0, C_ALU, 6'd0);
        dus_ready = 1'b1;
        repeat (3) cycle();
        dul_ready = 1'b1;
        repeat (3) cycle();

        // 4: steady enqueue and retire across pointer wrap. Count stays constant.
        set_ready(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, C_ALU, 6'(i));
            cycle();
        end
        alu_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1, C_ALU, 6'(i + 8));
            cycle();
        end
        drive(0, C_ALU, 6'd0);
        repeat (4) cycle();

        // 5: flush with 5 entries held and an enqueue in the same cycle.
        set_ready(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 3'(i % 4 + 1), 6'(i));
            cycle();
        end
        drive(1, C_ALU, 6'h11);
        alu_ready = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(0, C_ALU, 6'd0);
        repeat (2) cycle();

        // 6: unknown classes are dropped with a one-cycle illegal pulse.
        drive(1, 3'd0, 6'd0);
        cycle();
        drive(1, 3'd7, 6'h3f);
        cycle();
        drive(0, C_ALU, 6'd0);
        repeat (3) cycle();

        // Asynchronous reset mid-stream: the valids drop without a clock edge.
        set_ready(0, 0, 0, 0);
        drive(1, C_BU, 6'h04);
        cycle();
        drive(1, C_ALU, 6'h05);
        cycle();
        drive(0, C_ALU, 6'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_count",    64'(count),     64'd0);
        chk("rst_in_ready", 64'(in_ready),  64'd1);
        chk("rst_bu_valid", 64'(bu_valid),  64'd0);
        chk("rst_alu_valid",64'(alu_valid), 64'd0);
        chk("rst_illegal",  64'(illegal),   64'd0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
